// File: rtl/fixed_to_float_arb.sv
// fixed_to_float_arb
//   Arbitrates NUM_REQ requesters onto one shared, clock-enabled fixed-to-float
//   converter. Round-robin grant, one outstanding conversion per requester,
//   results returned through per-requester valid/ready holding registers.
//
// Ports
//   clk, rstn            : clock (rising edge), asynchronous active-low reset
//   enable               : permits new grants (in-flight work always drains)
//   req_valid/req_ready  : per-requester request handshake (req_ready one-hot)
//   req_integer/fraction : packed per-requester fixed-point operands
//   res_valid/res_ready  : per-requester result handshake
//   res_data             : packed per-requester float results
//   conv_clk_en          : converter clock enable (grant or any tag in flight)
//   conv_fixed_integer/fraction : operands muxed from the granted requester
//   conv_float_val       : converter result, CONV_LAT enabled cycles after input
//   inflight             : number of conversions currently in the converter
module fixed_to_float_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned INT_WID   = 32,
  parameter int unsigned FRA_WID   = 32,
  parameter int unsigned FLOAT_WID = 64,
  parameter int unsigned CONV_LAT  = 5
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*INT_WID-1:0]      req_integer,
  input  logic [NUM_REQ*FRA_WID-1:0]      req_fraction,
  output logic [NUM_REQ-1:0]              res_valid,
  input  logic [NUM_REQ-1:0]              res_ready,
  output logic [NUM_REQ*FLOAT_WID-1:0]    res_data,
  output logic                            conv_clk_en,
  output logic [INT_WID-1:0]              conv_fixed_integer,
  output logic [FRA_WID-1:0]              conv_fixed_fraction,
  input  logic [FLOAT_WID-1:0]            conv_float_val,
  output logic [$clog2(NUM_REQ+1)-1:0]    inflight
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]           busy_q, busy_d;
  logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CONV_LAT-1:0]          tag_v_q, tag_v_d;
  logic [IDX_W-1:0]             tag_idx_q [CONV_LAT];
  logic [IDX_W-1:0]             tag_idx_d [CONV_LAT];
  logic [NUM_REQ-1:0]           res_valid_q, res_valid_d;
  logic [NUM_REQ*FLOAT_WID-1:0] res_data_q, res_data_d;
  logic [CNT_W-1:0]             inflight_q, inflight_d;

  logic                         gnt_any;
  logic [IDX_W-1:0]             gnt_idx;
  logic [NUM_REQ-1:0]           gnt_onehot;
  logic                         capture;
  int unsigned                  cand;
  logic [IDX_W-1:0]             cand_idx;

  // Round-robin search from rr_ptr. Gated by rstn so nothing is granted
  // while the block is held in reset.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    if (enable && rstn) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!gnt_any && req_valid[cand_idx] && !busy_q[cand_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
    if (gnt_any) gnt_onehot[gnt_idx] = 1'b1;
  end

  always_comb begin
    conv_fixed_integer  = '0;
    conv_fixed_fraction = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && gnt_idx == IDX_W'(i)) begin
        conv_fixed_integer  = req_integer[i*INT_WID +: INT_WID];
        conv_fixed_fraction = req_fraction[i*FRA_WID +: FRA_WID];
      end
    end
  end

  assign capture     = tag_v_q[CONV_LAT-1];
  assign conv_clk_en = gnt_any | (|tag_v_q);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    tag_v_d     = tag_v_q;
    tag_idx_d   = tag_idx_q;
    res_data_d  = res_data_q;
    inflight_d  = inflight_q;
    // A result handshake frees the requester at this edge, so it can only be
    // re-granted in the following cycle.
    busy_d      = busy_q & ~(res_valid_q & res_ready);
    res_valid_d = res_valid_q & ~res_ready;

    if (gnt_any) begin
      busy_d[gnt_idx] = 1'b1;
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    // Tags move in lockstep with the converter's own enabled pipeline.
    if (conv_clk_en) begin
      tag_v_d[0]   = gnt_any;
      tag_idx_d[0] = gnt_idx;
      for (int unsigned k = 1; k < CONV_LAT; k++) begin
        tag_v_d[k]   = tag_v_q[k-1];
        tag_idx_d[k] = tag_idx_q[k-1];
      end
    end

    if (capture) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (tag_idx_q[CONV_LAT-1] == IDX_W'(i)) begin
          res_valid_d[i] = 1'b1;
          res_data_d[i*FLOAT_WID +: FLOAT_WID] = conv_float_val;
        end
      end
    end

    if (gnt_any && !capture) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!gnt_any && capture) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '{default: '0};
      res_valid_q <= '0;
      res_data_q  <= '0;
      inflight_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      inflight_q  <= inflight_d;
    end
  end

  assign req_ready = gnt_onehot;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_fixed_to_float_arb.sv
// Testbench for fixed_to_float_arb: converter model, queue-based reference
// model of arbitration/latency/results, directed scenarios, random traffic.
module tb_fixed_to_float_arb;

  localparam int NUM = 4;
  localparam int IW  = 32;
  localparam int FW  = 32;
  localparam int FLW = 64;
  localparam int LAT = 5;

  logic              clk;
  logic              rstn;
  logic              enable;
  logic [NUM-1:0]    req_valid;
  logic [NUM-1:0]    req_ready;
  logic [NUM*IW-1:0] req_integer;
  logic [NUM*FW-1:0] req_fraction;
  logic [NUM-1:0]    res_valid;
  logic [NUM-1:0]    res_ready;
  logic [NUM*FLW-1:0] res_data;
  logic              conv_clk_en;
  logic [IW-1:0]     conv_fixed_integer;
  logic [FW-1:0]     conv_fixed_fraction;
  logic [FLW-1:0]    conv_float_val;
  logic [$clog2(NUM+1)-1:0] inflight;

  fixed_to_float_arb #(
    .NUM_REQ  (NUM),
    .INT_WID  (IW),
    .FRA_WID  (FW),
    .FLOAT_WID(FLW),
    .CONV_LAT (LAT)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .enable             (enable),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_integer        (req_integer),
    .req_fraction       (req_fraction),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_data           (res_data),
    .conv_clk_en        (conv_clk_en),
    .conv_fixed_integer (conv_fixed_integer),
    .conv_fixed_fraction(conv_fixed_fraction),
    .conv_float_val     (conv_float_val),
    .inflight           (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed Q32.32 to IEEE double, round to nearest.
  function automatic logic [63:0] fx2f(input logic [31:0] ip, input logic [31:0] fp);
    real r;
    r = real'($signed(ip)) + real'(longint'({32'd0, fp})) / 4294967296.0;
    return $realtobits(r);
  endfunction

  // Converter: LAT enabled stages, reset together with the arbiter.
  logic [63:0] cpipe [LAT];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) cpipe[i] <= '0;
    end else if (conv_clk_en) begin
      cpipe[0] <= fx2f(conv_fixed_integer, conv_fixed_fraction);
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end
  assign conv_float_val = cpipe[LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: outstanding conversions as a queue with due edge numbers.
  typedef struct {
    int          idx;
    logic [63:0] data;
    int          due;
  } ent_t;
  ent_t        mq[$];
  bit          m_busy [NUM];
  bit          m_resv [NUM];
  logic [63:0] m_resd [NUM];
  int          m_ptr;
  int          edge_n;
  logic [NUM-1:0] last_rr;

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < NUM; i++) begin
      m_busy[i] = 0;
      m_resv[i] = 0;
      m_resd[i] = '0;
    end
    m_ptr = 0;
  endtask

  // Called at a negedge with inputs already driven. Checks outputs before the
  // rising edge, advances the model across it, returns at the next negedge.
  task automatic step();
    int g;
    logic [NUM-1:0] exp_rr;
    ent_t e;
    #1;
    g = -1;
    if (enable && rstn) begin
      for (int k = 0; k < NUM; k++) begin
        int c;
        c = (m_ptr + k) % NUM;
        if (g < 0 && req_valid[c] && !m_busy[c]) g = c;
      end
    end
    exp_rr = '0;
    if (g >= 0) exp_rr[g] = 1'b1;
    check_eq("req_ready", req_ready, exp_rr);
    check_eq("conv_clk_en", conv_clk_en, (g >= 0 || mq.size() > 0) ? 1 : 0);
    check_eq("conv_int", conv_fixed_integer, (g >= 0) ? req_integer[g*IW +: IW] : 0);
    check_eq("conv_frac", conv_fixed_fraction, (g >= 0) ? req_fraction[g*FW +: FW] : 0);
    check_eq("inflight", inflight, mq.size());
    for (int i = 0; i < NUM; i++) begin
      check_eq("res_valid", res_valid[i], m_resv[i]);
      if (m_resv[i]) check_eq("res_data", res_data[i*FLW +: FLW], m_resd[i]);
    end
    last_rr = req_ready;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < NUM; i++) begin
      if (m_resv[i] && res_ready[i]) begin
        m_resv[i] = 0;
        m_busy[i] = 0;
      end
    end
    while (mq.size() > 0 && mq[0].due == edge_n) begin
      e = mq.pop_front();
      m_resv[e.idx] = 1;
      m_resd[e.idx] = e.data;
    end
    if (g >= 0) begin
      m_busy[g] = 1;
      e.idx  = g;
      e.data = fx2f(req_integer[g*IW +: IW], req_fraction[g*FW +: FW]);
      e.due  = edge_n + LAT;
      mq.push_back(e);
      m_ptr = (g + 1) % NUM;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " req_ready"}, req_ready, 0);
    check_eq({tag, " conv_clk_en"}, conv_clk_en, 0);
    check_eq({tag, " inflight"}, inflight, 0);
    check_eq({tag, " res_valid"}, res_valid, 0);
    check_eq({tag, " res_data0"}, res_data[63:0], 0);
    check_eq({tag, " res_data3"}, res_data[255:192], 0);
    check_eq({tag, " conv_int"}, conv_fixed_integer, 0);
    check_eq({tag, " conv_frac"}, conv_fixed_fraction, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic single_conv(input int idx, input logic [31:0] ip, input logic [31:0] fp,
                             input logic [63:0] exp, input string tag);
    int lat;
    req_integer[idx*IW +: IW]  = ip;
    req_fraction[idx*FW +: FW] = fp;
    res_ready = '1;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    step();
    check_eq({tag, " accept"}, last_rr, 64'(1) << idx);
    req_valid = '0;
    lat = 1;
    while (!res_valid[idx] && lat < 20) begin
      step();
      lat++;
    end
    check_eq({tag, " latency"}, lat, LAT + 1);
    check_eq({tag, " data"}, res_data[idx*FLW +: FLW], exp);
    step();
    req_valid[idx] = 1'b1;
    step();
    check_eq({tag, " regrant after release"}, last_rr, 64'(1) << idx);
    req_valid = '0;
    repeat (8) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp20 [4];
    int          ord [4];
    logic [63:0] dat [4];
    int          n, t, peak, others, n_del, n_gnt;
    logic [63:0] d1;

    exp20[0] = 64'hC000000000000000;
    exp20[1] = 64'h0000000000000000;
    exp20[2] = 64'h3FE0000000000000;
    exp20[3] = 64'h4008000000000000;

    rstn = 1'b0;
    enable = 1'b1;
    req_valid = 4'b1111;
    res_ready = '0;
    req_integer = '0;
    req_fraction = '0;
    edge_n = 0;
    last_rr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("initial reset");
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;

    // Single conversion of 1.0 on requester 0.
    single_conv(0, 32'd1, 32'd0, 64'h3FF0000000000000, "req0 one");

    // All four requesters at once from rr_ptr = 0.
    do_reset();
    req_integer  = {32'd3, 32'd0, 32'd0, 32'hFFFFFFFE};
    req_fraction = {32'd0, 32'h80000000, 32'd0, 32'd0};
    req_valid = 4'b1111;
    res_ready = 4'b1111;
    peak = 0;
    for (int k = 0; k < NUM; k++) begin
      step();
      check_eq("all4 grant order", last_rr, 64'(1) << k);
      req_valid = req_valid & ~last_rr;
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    check_eq("all4 inflight peak", peak, 4);
    n = 0;
    t = 0;
    while (n < 4 && t < 20) begin
      step();
      t++;
      for (int i = 0; i < NUM; i++) begin
        if (res_valid[i] && n < 4) begin
          ord[n] = i;
          dat[n] = res_data[i*FLW +: FLW];
          n++;
        end
      end
    end
    check_eq("all4 result count", n, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("all4 result order", ord[k], k);
      check_eq("all4 result data", dat[k], exp20[k]);
    end

    // rr_ptr wrapped to 0 after req3: req0 goes before req3.
    req_valid = 4'b1001;
    step();
    check_eq("wrap first grant", last_rr, 4'b0001);
    req_valid = 4'b1000;
    step();
    check_eq("wrap second grant", last_rr, 4'b1000);
    req_valid = '0;
    repeat (8) step();

    // Requester 1 result held back while others keep flowing.
    for (int i = 0; i < NUM; i++) begin
      req_integer[i*IW +: IW]  = $urandom;
      req_fraction[i*FW +: FW] = $urandom;
    end
    res_ready = 4'b1101;
    req_valid = 4'b1111;
    t = 0;
    while (!res_valid[1] && t < 40) begin
      step();
      t++;
    end
    check_eq("hold req1 result seen", res_valid[1], 1);
    d1 = res_data[FLW +: FLW];
    others = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("hold req1 not granted", last_rr[1], 0);
      check_eq("hold req1 valid", res_valid[1], 1);
      check_eq("hold req1 data stable", res_data[FLW +: FLW], d1);
      if ((last_rr & 4'b1101) != 0) others++;
    end
    check_eq("hold others served", (others > 0) ? 1 : 0, 1);
    res_ready = 4'b1111;
    step();
    req_valid = '0;
    repeat (10) step();

    // Drain with enable low.
    req_valid = 4'b0011;
    enable = 1'b1;
    step();
    step();
    check_eq("drain inflight", inflight, 2);
    enable = 1'b0;
    req_valid = 4'b1111;
    n_del = 0;
    n_gnt = 0;
    repeat (12) begin
      step();
      if (last_rr != 0) n_gnt++;
      n_del += $countones(res_valid);
    end
    check_eq("drain deliveries", n_del, 2);
    check_eq("drain no grants", n_gnt, 0);
    check_eq("drain clk_en low", conv_clk_en, 0);
    check_eq("drain inflight zero", inflight, 0);
    enable = 1'b1;
    req_valid = '0;

    // Reset with three conversions in flight.
    req_valid = 4'b0111;
    repeat (3) step();
    check_eq("midreset inflight", inflight, 3);
    do_reset();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      check_eq("midreset no result", res_valid, 0);
    end
    single_conv(2, 32'd1, 32'd0, 64'h3FF0000000000000, "post reset");

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM; i++) begin
        req_integer[i*IW +: IW] = ($urandom_range(0, 3) == 0) ? $urandom
                                  : 32'($urandom_range(0, 20)) - 32'd10;
        req_fraction[i*FW +: FW] = $urandom;
      end
      req_valid = 4'($urandom);
      res_ready = 4'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fixed_to_float_arb.md
FIXED_TO_FLOAT_ARB -- requirements
Module: fixed_to_float_arb

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, default 4, number of requesters.
- INT_WID, default 32, fixed-point integer width.
- FRA_WID, default 32, fixed-point fraction width.
- FLOAT_WID, default 64, float result width.
- CONV_LAT, default 5, converter latency in enabled cycles.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  permits new grants.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept.
- req_integer  in  NUM_REQ*INT_WID  packed signed integer parts.
- req_fraction  in  NUM_REQ*FRA_WID  packed fraction parts.
- res_valid  out  NUM_REQ  per-requester result valid.
- res_ready  in  NUM_REQ  per-requester result accept.
- res_data  out  NUM_REQ*FLOAT_WID  packed per-requester results.
- conv_clk_en  out  1  converter clock enable.
- conv_fixed_integer  out  INT_WID  converter integer input.
- conv_fixed_fraction  out  FRA_WID  converter fraction input.
- conv_float_val  in  FLOAT_WID  converter result.
- inflight  out  $clog2(NUM_REQ+1)  count of conversions in the converter.

REQ-003 Clock and reset SHALL be clk and rstn only: one clock domain, reset asynchronous and active-low.

Function
REQ-004 Requester i SHALL be eligible when busy[i]=0. busy[i] SHALL set on request handshake and clear on result handshake (res_valid[i]&res_ready[i]). Each requester SHALL have at most one outstanding conversion.

REQ-005 Each cycle, when enable=1, exactly one grant SHALL go to the first eligible requester with req_valid=1. The search SHALL start at rr_ptr and wrap modulo NUM_REQ. req_ready SHALL be that one-hot grant (combinational from req_valid, busy, rr_ptr); otherwise req_ready SHALL be all zeros.

REQ-006 On a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ at the next edge. With no grant, rr_ptr SHALL hold.

REQ-007 conv_fixed_integer/fraction SHALL be the muxed slice of the granted requester. With no grant they SHALL be zero.

REQ-008 conv_clk_en SHALL equal (grant issued) OR (any tag valid). It SHALL be combinational and SHALL be low when idle.

REQ-009 A CONV_LAT-deep tag pipeline (valid + requester index) SHALL shift only when conv_clk_en=1. Stage 0 SHALL load the grant.

REQ-010 When tag stage CONV_LAT-1 is valid, conv_float_val SHALL be captured at that edge into res_data slice of the tagged index, setting res_valid for it. conv_clk_en is guaranteed 1 at that edge.

REQ-011 Latency from request handshake edge to res_valid high SHALL be CONV_LAT+1 cycles (6 by default). Back-to-back grants SHALL sustain one conversion per cycle across distinct requesters.

REQ-012 res_valid[i] and res_data slice i SHALL hold stable until res_ready[i]. A result handshake and a new grant to the same i SHALL NOT coincide, because busy clears one cycle after the handshake.

REQ-013 inflight SHALL count valid tag stages: +1 on grant, -1 on capture, and unchanged when both occur in the same cycle.

REQ-014 If enable deasserts, in-flight conversions SHALL drain and deliver results normally. Pending req_valid SHALL wait.

REQ-015 Converter done output SHALL NOT be used; sequencing relies solely on tags.

Reset
REQ-016 On rstn low, asynchronously, the following SHALL clear: busy, rr_ptr=0, tags, res_valid, res_data, and inflight=0. conv_clk_en, req_ready and the conv inputs SHALL then be 0.

REQ-017 Reset mid-operation SHALL discard in-flight conversions with no result delivered. rstn SHALL also reset the converter.

REQ-018 After rstn release, the first grant SHALL be possible in the first cycle.

Verification
REQ-019 Req0 integer=1, fraction=0, res_ready=1 -> res_valid[0] 6 cycles after accept, res_data=0x3FF0000000000000, then busy[0] clears.

REQ-020 All four requesters valid simultaneously (integer=-2, 0, fraction 0x80000000 on req2, 3) -> grants in order 0,1,2,3 on consecutive cycles. Results in order: 0xC000000000000000, 0x0, 0x3FE0000000000000, 0x4008000000000000 (3.0). inflight peaks at 4.

REQ-021 Req1 result held with res_ready[1]=0 for 20 cycles while req1 stays valid -> req_ready[1] stays 0 and res_data stable. Other requesters continue to be served.

REQ-022 enable=0 with two conversions in flight -> both results delivered, no new grant, and conv_clk_en falls to 0 once tags are empty.

REQ-023 rstn pulse low with three in flight -> all outputs zero immediately, no res_valid afterward, and a new request completes correctly in 6 cycles.

REQ-024 Req3 granted, then req0 and req3 both valid -> rr_ptr=0 grants req0 before req3 (wrap-around check).
